div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width in bits; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request strobe, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have ports rs1_dat and rs2_dat, input, WIDTH bits each: dividend and divisor, taken from the register file read ports rd1/rd2.
REQ-007 The block SHALL have port rd_in, input, 5 bits, the destination register index, captured with the operands.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever state != IDLE.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle result-valid pulse.
REQ-010 The block SHALL have port result, output, WIDTH bits, the value for register file write data.
REQ-011 The block SHALL have port rd_out, output, 5 bits, the captured destination index.
REQ-012 The block SHALL have port regWrite, output, 1 bit, driving the register file write enable.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 On a clock edge with state IDLE and start=1, the block SHALL capture op, operands and rd_in, compute absolute values for signed ops, and go to CALC with iteration count 0.
REQ-015 Special cases SHALL bypass CALC and go IDLE->DONE on the start edge, giving a latency of 1 clock: divisor 0 gives quotient 0xFFFFFFFF and remainder = dividend (raw, unsigned view); DIV/REM with 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle, producing quotient bits MSB first, for exactly 32 cycles; the partial remainder SHALL be WIDTH+1 bits to hold the borrow.
REQ-017 After the 32nd CALC edge the block SHALL enter DONE, giving a latency of 33 clocks from the start edge to the done cycle.
REQ-018 Sign fixup SHALL apply for signed ops: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
REQ-019 result SHALL carry the quotient for DIV/DIVU and the remainder for REM/REMU, registered and stable while done=1.
REQ-020 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL go to IDLE unconditionally.
REQ-021 regWrite SHALL equal done & (rd_out != 0); a write to x0 is suppressed.
REQ-022 start SHALL be ignored in CALC and DONE, with no queuing and no corruption of the operation in flight.
REQ-023 start asserted in the IDLE cycle immediately after DONE SHALL be accepted, giving a throughput of one op per 34 cycles.
REQ-024 Operand inputs SHALL NOT be required to stay stable after the start edge.

Reset
REQ-025 reset=0 SHALL force state IDLE, busy=0, done=0, regWrite=0, result=0, rd_out=0, and clear the internal count, quotient and remainder, immediately and asynchronously.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no done pulse after release; the first start after reset deassertion SHALL be accepted normally.

Verification
REQ-027 A bench SHALL check DIVU: 100 / 7, rd_in=5 -> done at clock 33 after start, result=14, rd_out=5, regWrite=1.
REQ-028 A bench SHALL check REM: 0xFFFFFFF9 (-7) % 2 -> result=0xFFFFFFFF (-1); and DIV: -7/2 -> 0xFFFFFFFD (-3).
REQ-029 A bench SHALL check DIV: 123 / 0 -> done at clock 1, result=0xFFFFFFFF; and REMU: 123 % 0 -> result=123.
REQ-030 A bench SHALL check DIV: 0x80000000 / 0xFFFFFFFF -> result=0x80000000, latency 1; REM on the same operands -> 0.
REQ-031 A bench SHALL check rd_in=0 on any valid op -> done=1, regWrite=0.
REQ-032 A bench SHALL check start pulsed at clock 10 of CALC -> ignored, first result unchanged; reset low at clock 10 -> busy=0 at once, no done, and a new op after release completes correctly.

Source files
------------

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit -- iterative RV32M divider (DIV, DIVU, REM, REMU).
//
// A restoring shift-subtract divider that produces one quotient bit per clock,
// MSB first. Divide-by-zero and signed overflow are resolved in one clock
// without iterating. Normal operations complete 33 clocks after the start
// edge, and the next operation can start in the IDLE cycle that follows DONE.
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   asynchronous, active-low reset
//   start    in   request strobe, sampled only in IDLE
//   op       in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_dat  in   dividend (WIDTH bits)
//   rs2_dat  in   divisor  (WIDTH bits)
//   rd_in    in   destination register index, captured with the operands
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  one-cycle result-valid pulse
//   result   out  quotient (DIV/DIVU) or remainder (REM/REMU), registered
//   rd_out   out  captured destination register index
//   regWrite out  register file write enable (done and rd_out != x0)
// ----------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1_dat,
   input  logic [WIDTH-1:0] rs2_dat,
   input  logic [4:0]       rd_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       rd_out,
   output logic             regWrite
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [5:0]       count;
   logic [WIDTH-1:0] quot;      // dividend shifts out the top, quotient bits shift in
   logic [WIDTH:0]   rem;       // extra bit holds the borrow of the trial subtract
   logic [WIDTH-1:0] divisor;
   logic             is_rem;
   logic             neg_q;
   logic             neg_r;

   // Operand decode for the start edge.
   logic             signed_op;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             div_zero;
   logic             overflow;

   // One restoring step.
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quot_next;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // NOTE: every signal gets a default at the top of always_comb, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      signed_op = ~op[0];
      abs_a     = rs1_dat;
      abs_b     = rs2_dat;
      if (signed_op && rs1_dat[WIDTH-1]) abs_a = -rs1_dat;
      if (signed_op && rs2_dat[WIDTH-1]) abs_b = -rs2_dat;
      div_zero  = (rs2_dat == '0);
      overflow  = signed_op && (rs1_dat == {1'b1, {(WIDTH-1){1'b0}}})
                            && (rs2_dat == '1);

      rem_shift = {rem[WIDTH-1:0], quot[WIDTH-1]};
      trial     = rem_shift - {1'b0, divisor};
      rem_next  = rem_shift;
      quot_next = {quot[WIDTH-2:0], 1'b0};
      // The remainder is always below the divisor, so the top bit of the
      // trial difference is set exactly when the subtract would borrow.
      if (!trial[WIDTH]) begin
         rem_next  = trial;
         quot_next = {quot[WIDTH-2:0], 1'b1};
      end

      q_fix = neg_q ? -quot_next : quot_next;
      r_fix = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         count    <= '0;
         quot     <= '0;
         rem      <= '0;
         divisor  <= '0;
         is_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         rd_out   <= '0;
         regWrite <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rd_out <= rd_in;
                  is_rem <= op[1];
                  busy   <= 1'b1;
                  if (div_zero || overflow) begin
                     // Divide-by-zero: raw dividend as remainder, all-ones
                     // quotient. Overflow: quotient is the dividend, rem 0.
                     if (div_zero) result <= op[1] ? rs1_dat : '1;
                     else          result <= op[1] ? '0 : rs1_dat;
                     done     <= 1'b1;
                     regWrite <= (rd_in != 5'd0);
                     state    <= DONE;
                  end else begin
                     quot    <= abs_a;
                     rem     <= '0;
                     divisor <= abs_b;
                     count   <= '0;
                     neg_q   <= signed_op && (rs1_dat[WIDTH-1] ^ rs2_dat[WIDTH-1]);
                     neg_r   <= signed_op && rs1_dat[WIDTH-1];
                     state   <= CALC;
                  end
               end
            end

            CALC: begin
               quot  <= quot_next;
               rem   <= rem_next;
               count <= count + 6'd1;
               if (count == 6'(WIDTH - 1)) begin
                  result   <= is_rem ? r_fix : q_fix;
                  done     <= 1'b1;
                  regWrite <= (rd_out != 5'd0);
                  state    <= DONE;
               end
            end

            DONE: begin
               done     <= 1'b0;
               regWrite <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               done     <= 1'b0;
               regWrite <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit -- directed, table-driven bench for div_unit.
// Each vector gives op, operands, rd and the hand-computed result and latency
// (clock edges from the start edge, inclusive, to the first done cycle).
// ----------------------------------------------------------------------------
module tb_div_unit;

   localparam int WIDTH = 32;

   logic             clk;
   logic             reset;
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs1_dat;
   logic [WIDTH-1:0] rs2_dat;
   logic [4:0]       rd_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [4:0]       rd_out;
   logic             regWrite;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp_result;
      int          exp_lat;
   } vec_t;

   div_unit #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rs1_dat  (rs1_dat),
      .rs2_dat  (rs2_dat),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out),
      .regWrite (regWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge while the DUT is IDLE. Returns at the negedge of the
   // IDLE cycle after DONE, so a following call starts back-to-back.
   // glitch_at > 0 pulses start with a junk op during that cycle of the run.
   task automatic run_op(input vec_t v, input int glitch_at);
      int lat;
      op      = v.op;
      rs1_dat = v.a;
      rs2_dat = v.b;
      rd_in   = v.rd;
      start   = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      // Operands are scrambled after the start edge; the DUT must not care.
      start   = 1'b0;
      rs1_dat = $urandom;
      rs2_dat = $urandom;
      rd_in   = 5'(~v.rd);
      op      = ~v.op;
      while (!done && lat < 100) begin
         if (lat == glitch_at) begin
            start   = 1'b1;
            op      = OP_DIV;
            rs2_dat = '0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("done_seen op=%0d a=%h", v.op, v.a), 32'(done), 32'd1);
      check($sformatf("latency op=%0d a=%h b=%h", v.op, v.a, v.b), 32'(lat), 32'(v.exp_lat));
      check($sformatf("result op=%0d a=%h b=%h", v.op, v.a, v.b), result, v.exp_result);
      check("rd_out", 32'(rd_out), 32'(v.rd));
      check("regWrite", 32'(regWrite), 32'(v.rd != 5'd0));
      check("busy_in_done", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      vec_t v;
      int   seen_done;

      vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        5'd5,  32'd14,         33});
      vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,        5'd3,  32'hFFFF_FFFF,  33});
      vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,        5'd4,  32'hFFFF_FFFD,  33});
      vecs.push_back('{OP_DIV,  32'd123,        32'd0,        5'd6,  32'hFFFF_FFFF,  1});
      vecs.push_back('{OP_REMU, 32'd123,        32'd0,        5'd7,  32'd123,        1});
      vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd8, 32'h8000_0000,  1});
      vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd9, 32'd0,          1});
      vecs.push_back('{OP_DIVU, 32'd100,        32'd7,        5'd0,  32'd14,         33});
      vecs.push_back('{OP_REMU, 32'hFFFF_FFFF,  32'd10,       5'd10, 32'd5,          33});
      vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        5'd11, 32'hFFFF_FFFF,  33});
      vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         33});
      vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 33});
      vecs.push_back('{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE, 5'd14, 32'd4,         33});
      vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         33});
      vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 33});
      vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd0,        5'd17, 32'hFFFF_FFF9,  1});

      start   = 1'b0;
      op      = OP_DIV;
      rs1_dat = '0;
      rs2_dat = '0;
      rd_in   = '0;
      reset   = 1'b0;
      #12;
      check("reset_busy",     32'(busy),     32'd0);
      check("reset_done",     32'(done),     32'd0);
      check("reset_regWrite", 32'(regWrite), 32'd0);
      check("reset_result",   result,        32'd0);
      check("reset_rd_out",   32'(rd_out),   32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Back-to-back table: each op starts in the IDLE cycle right after DONE.
      foreach (vecs[i]) run_op(vecs[i], 0);

      // start pulsed during CALC (a would-be divide-by-zero) must be ignored.
      v = '{OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33};
      run_op(v, 10);

      // Reset in mid-CALC aborts the op immediately with no later done.
      op      = OP_DIVU;
      rs1_dat = 32'd1000;
      rs2_dat = 32'd3;
      rd_in   = 5'd9;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("calc_busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_busy",     32'(busy),     32'd0);
      check("abort_done",     32'(done),     32'd0);
      check("abort_regWrite", 32'(regWrite), 32'd0);
      check("abort_result",   result,        32'd0);
      check("abort_rd_out",   32'(rd_out),   32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      check("no_done_after_abort", 32'(seen_done), 32'd0);

      v = '{OP_DIV, 32'hFFFF_FC18, 32'd3, 5'd21, 32'hFFFF_FEB3, 33};  // -1000/3 = -333
      run_op(v, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
